// File: rtl/icache.sv
// Direct-mapped instruction cache: one instruction per line, one-cycle hits,
// single outstanding miss to the memory controller.
module icache #(
  parameter int ICACHE_SIZE_WIDTH = 6,
  parameter int XLEN              = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            stall,
  input  logic            ifetch_enable,
  input  logic [XLEN-1:0] ifetch_pc,
  output logic            icache_ready,
  output logic [XLEN-1:0] icache_inst,
  output logic [XLEN-1:0] icache_pc,
  input  logic            mem_busy,
  input  logic            mem_inst_ready,
  input  logic [XLEN-1:0] mem_inst,
  input  logic [XLEN-1:0] mem_inst_addr,
  output logic            icache_mem_enable,
  output logic [XLEN-1:0] icache_inst_addr
);

  localparam int Lines = 1 << ICACHE_SIZE_WIDTH;
  localparam int TagW  = XLEN - ICACHE_SIZE_WIDTH - 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   miss_addr_q, miss_addr_d;
  logic              armed_q, armed_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              mem_en;
  logic              fill;

  logic [Lines-1:0]  valid_q;
  logic [TagW-1:0]   tag_arr [Lines];
  logic [XLEN-1:0]   data_arr [Lines];

  logic [ICACHE_SIZE_WIDTH-1:0] lookup_idx;
  logic [TagW-1:0]              lookup_tag;
  logic [ICACHE_SIZE_WIDTH-1:0] fill_idx;
  logic [TagW-1:0]              fill_tag;
  logic                         hit;

  assign lookup_idx = ifetch_pc[ICACHE_SIZE_WIDTH:1];
  assign lookup_tag = ifetch_pc[XLEN-1:ICACHE_SIZE_WIDTH+1];
  assign fill_idx   = miss_addr_q[ICACHE_SIZE_WIDTH:1];
  assign fill_tag   = miss_addr_q[XLEN-1:ICACHE_SIZE_WIDTH+1];
  assign hit        = valid_q[lookup_idx] && (tag_arr[lookup_idx] == lookup_tag);

  assign icache_ready      = ready_q;
  assign icache_inst       = inst_q;
  assign icache_pc         = pc_q;
  assign icache_mem_enable = mem_en;
  assign icache_inst_addr  = miss_addr_q;

  // Next-state logic: flush beats stall, rdy low freezes everything.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    armed_d     = armed_q;
    ready_d     = 1'b0;
    inst_d      = inst_q;
    pc_d        = pc_q;
    mem_en      = 1'b0;
    fill        = 1'b0;
    if (!rdy) begin
      ready_d = ready_q;
    end else if (flush) begin
      // Outstanding miss is abandoned; a same-cycle fill is dropped.
      state_d = StIdle;
    end else if (stall) begin
      ready_d = ready_q;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ifetch_enable) begin
            if (hit) begin
              ready_d = 1'b1;
              inst_d  = data_arr[lookup_idx];
              pc_d    = ifetch_pc;
            end else begin
              miss_addr_d = ifetch_pc;
              state_d     = StReq;
            end
          end
        end
        StReq: begin
          if (!mem_busy) begin
            mem_en  = 1'b1;
            armed_d = 1'b0;
            state_d = StWait;
          end
        end
        StWait: begin
          // First WAIT cycle only arms; a return seen then is stale.
          if (!armed_q) begin
            armed_d = 1'b1;
          end else if (mem_inst_ready && (mem_inst_addr == miss_addr_q)) begin
            fill    = 1'b1;
            ready_d = 1'b1;
            inst_d  = mem_inst;
            pc_d    = miss_addr_q;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      armed_q     <= 1'b0;
      ready_q     <= 1'b0;
      inst_q      <= '0;
      pc_q        <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      armed_q     <= armed_d;
      ready_q     <= ready_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
    end
  end

  // Valid bits: cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem_inst;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed table, corner sequences and a
// randomized run against an address-level reference model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        stall;
  logic        ifetch_enable;
  logic [31:0] ifetch_pc;
  logic        icache_ready;
  logic [31:0] icache_inst;
  logic [31:0] icache_pc;
  logic        mem_busy;
  logic        mem_inst_ready;
  logic [31:0] mem_inst;
  logic [31:0] mem_inst_addr;
  logic        icache_mem_enable;
  logic [31:0] icache_inst_addr;

  int checks = 0;
  int errors = 0;

  // Reference model: per index, which full halfword address (pc>>1) is resident.
  bit          m_valid [64];
  logic [30:0] m_line  [64];
  logic [31:0] m_data  [64];

  typedef struct {
    logic [31:0] pc;
    bit          hit;
    logic [31:0] inst;
  } vec_t;
  vec_t tbl [12];

  icache #(.ICACHE_SIZE_WIDTH(6), .XLEN(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .flush             (flush),
    .stall             (stall),
    .ifetch_enable     (ifetch_enable),
    .ifetch_pc         (ifetch_pc),
    .icache_ready      (icache_ready),
    .icache_inst       (icache_inst),
    .icache_pc         (icache_pc),
    .mem_busy          (mem_busy),
    .mem_inst_ready    (mem_inst_ready),
    .mem_inst          (mem_inst),
    .mem_inst_addr     (mem_inst_addr),
    .icache_mem_enable (icache_mem_enable),
    .icache_inst_addr  (icache_inst_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a[1]) return {16'h0000, a[15:0] ^ 16'hC001};
    return {a[15:0] ^ 16'h5A5A, a[15:0] | 16'h0003};
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[6:1]] && (m_line[pc[6:1]] == pc[31:1]);
  endfunction

  function automatic void model_fill(input logic [31:0] pc, input logic [31:0] d);
    m_valid[pc[6:1]] = 1'b1;
    m_line[pc[6:1]]  = pc[31:1];
    m_data[pc[6:1]]  = d;
  endfunction

  // One fetch; on a miss also plays the memory controller.
  task automatic fetch(input logic [31:0] pc, input bit exp_hit, input logic [31:0] inst,
                       input int extra_wait, input bit bad_ret);
    ifetch_enable = 1'b1;
    ifetch_pc     = pc;
    step();
    if (exp_hit) begin
      chk("hit_ready", {31'b0, icache_ready}, 32'd1);
      chk("hit_inst", icache_inst, inst);
      chk("hit_pc", icache_pc, pc);
      chk("hit_no_mem", {31'b0, icache_mem_enable}, 32'd0);
    end else begin
      chk("miss_ready", {31'b0, icache_ready}, 32'd0);
      chk("miss_req", {31'b0, icache_mem_enable}, 32'd1);
      chk("miss_addr", icache_inst_addr, pc);
      step();
      chk("req_single_pulse", {31'b0, icache_mem_enable}, 32'd0);
      // Stale return in the first WAIT cycle must be ignored.
      mem_inst_ready = 1'b1;
      mem_inst_addr  = pc;
      mem_inst       = ~inst;
      step();
      mem_inst_ready = 1'b0;
      chk("stale_ignored", {31'b0, icache_ready}, 32'd0);
      repeat (extra_wait + 1) step();
      if (bad_ret) begin
        mem_inst_ready = 1'b1;
        mem_inst_addr  = pc ^ 32'h0000_0400;
        mem_inst       = ~inst;
        step();
        mem_inst_ready = 1'b0;
        chk("bad_addr_ignored", {31'b0, icache_ready}, 32'd0);
      end
      mem_inst_ready = 1'b1;
      mem_inst_addr  = pc;
      mem_inst       = inst;
      step();
      mem_inst_ready = 1'b0;
      chk("fill_ready", {31'b0, icache_ready}, 32'd1);
      chk("fill_inst", icache_inst, inst);
      chk("fill_pc", icache_pc, pc);
      model_fill(pc, inst);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    bit          h;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = 1'b0;
    ifetch_enable = 1'b0; ifetch_pc = '0;
    mem_busy = 1'b0; mem_inst_ready = 1'b0; mem_inst = '0; mem_inst_addr = '0;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_line[i] = '0; m_data[i] = '0;
    end
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state.
    chk("rst_ready", {31'b0, icache_ready}, 32'd0);
    chk("rst_inst", icache_inst, 32'd0);
    chk("rst_pc", icache_pc, 32'd0);
    chk("rst_mem_en", {31'b0, icache_mem_enable}, 32'd0);
    chk("rst_inst_addr", icache_inst_addr, 32'd0);

    // Directed table: first miss, streaming hits, conflict, compressed.
    tbl[0]  = '{32'h0000_0000, 1'b0, 32'h0000_0513};
    tbl[1]  = '{32'h0000_0000, 1'b1, 32'h0000_0513};
    tbl[2]  = '{32'h0000_0004, 1'b0, 32'h0000_0593};
    tbl[3]  = '{32'h0000_0008, 1'b0, 32'h0000_0613};
    tbl[4]  = '{32'h0000_0000, 1'b1, 32'h0000_0513};
    tbl[5]  = '{32'h0000_0004, 1'b1, 32'h0000_0593};
    tbl[6]  = '{32'h0000_0008, 1'b1, 32'h0000_0613};
    tbl[7]  = '{32'h0000_0084, 1'b0, 32'h0010_0093};
    tbl[8]  = '{32'h0000_0004, 1'b0, 32'h0000_0593};
    tbl[9]  = '{32'h0000_0002, 1'b0, 32'h0000_4501};
    tbl[10] = '{32'h0000_0002, 1'b1, 32'h0000_4501};
    tbl[11] = '{32'h0000_0000, 1'b1, 32'h0000_0513};
    for (int i = 0; i < 12; i++) fetch(tbl[i].pc, tbl[i].hit, tbl[i].inst, 0, 1'b0);
    ifetch_enable = 1'b0;
    step();

    // Flush while waiting, with the fill arriving in the flush cycle.
    ifetch_enable = 1'b1;
    ifetch_pc     = 32'h0000_0100;
    step();
    chk("fl_req", {31'b0, icache_mem_enable}, 32'd1);
    ifetch_enable = 1'b0;
    step();
    step();
    flush          = 1'b1;
    mem_inst_ready = 1'b1;
    mem_inst_addr  = 32'h0000_0100;
    mem_inst       = 32'hDEAD_BEEF;
    step();
    flush = 1'b0;
    chk("fl_no_ready0", {31'b0, icache_ready}, 32'd0);
    step();
    chk("fl_no_ready1", {31'b0, icache_ready}, 32'd0);
    step();
    chk("fl_no_ready2", {31'b0, icache_ready}, 32'd0);
    mem_inst_ready = 1'b0;
    fetch(32'h0000_0000, 1'b1, 32'h0000_0513, 0, 1'b0);
    fetch(32'h0000_0100, 1'b0, memval(32'h0000_0100), 1, 1'b0);
    ifetch_enable = 1'b0;
    step();

    // Busy controller holds the request; stall delays it one more cycle.
    mem_busy      = 1'b1;
    ifetch_enable = 1'b1;
    ifetch_pc     = 32'h0000_020C;
    step();
    chk("busy_0", {31'b0, icache_mem_enable}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      step();
      chk("busy_n", {31'b0, icache_mem_enable}, 32'd0);
    end
    mem_busy = 1'b0;
    stall    = 1'b1;
    #1;
    chk("stall_blocks", {31'b0, icache_mem_enable}, 32'd0);
    step();
    stall = 1'b0;
    #1;
    chk("busy_release", {31'b0, icache_mem_enable}, 32'd1);
    chk("busy_addr", icache_inst_addr, 32'h0000_020C);
    step();
    step();
    mem_inst_ready = 1'b1;
    mem_inst_addr  = 32'h0000_020C;
    mem_inst       = memval(32'h0000_020C);
    step();
    mem_inst_ready = 1'b0;
    chk("busy_fill_ready", {31'b0, icache_ready}, 32'd1);
    chk("busy_fill_inst", icache_inst, memval(32'h0000_020C));
    model_fill(32'h0000_020C, memval(32'h0000_020C));
    fetch(32'h0000_020C, 1'b1, memval(32'h0000_020C), 0, 1'b0);

    // Randomized fetches over a small address pool to force reuse and conflicts.
    for (int i = 0; i < 80; i++) begin
      pc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 15)) << 1);
      h  = model_hit(pc);
      fetch(pc, h, h ? m_data[pc[6:1]] : memval(pc), int'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0);
    end
    ifetch_enable = 1'b0;
    step();

    // Asynchronous reset in the middle of a miss.
    ifetch_enable = 1'b1;
    ifetch_pc     = 32'h8000_0040;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("amid_ready", {31'b0, icache_ready}, 32'd0);
    chk("amid_inst", icache_inst, 32'd0);
    chk("amid_pc", icache_pc, 32'd0);
    chk("amid_mem_en", {31'b0, icache_mem_enable}, 32'd0);
    chk("amid_inst_addr", icache_inst_addr, 32'd0);
    ifetch_enable = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    step();
    fetch(32'h0000_0000, 1'b0, memval(32'h0000_0000), 0, 1'b0);
    fetch(32'h0000_0000, 1'b1, memval(32'h0000_0000), 0, 1'b0);
    ifetch_enable = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the instruction-fetch stage and the memory controller. It serves fetch requests from a tag/data array with one-cycle hit latency. On a miss it issues a single instruction-load request to the memory controller, fills the line from the returned instruction (16-bit compressed or 32-bit), and forwards that instruction to fetch. It obeys the global `rdy`, `stall` and `flush` controls used throughout the core.

## Interface
- `ICACHE_SIZE_WIDTH`, default 6: log2 of line count (64 lines). One line holds one instruction.
- `XLEN`, default 32: address and instruction width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `rdy` in 1: global ready; when low, all state is frozen.
- `flush` in 1: pipeline flush from misprediction.
- `stall` in 1: global stall; freezes all state.
- `ifetch_enable` in 1: fetch request valid.
- `ifetch_pc` in XLEN: fetch address, 2-byte aligned.
- `icache_ready` out 1: one-cycle pulse; `icache_inst` is valid for `icache_pc`.
- `icache_inst` out XLEN: instruction. Upper 16 bits are 0 for compressed instructions.
- `icache_pc` out XLEN: address of the returned instruction.
- `mem_busy` in 1: memory controller busy.
- `mem_inst_ready` in 1: memory controller instruction return valid.
- `mem_inst` in XLEN: returned instruction.
- `mem_inst_addr` in XLEN: address of the returned instruction.
- `icache_mem_enable` out 1: miss request to the memory controller.
- `icache_inst_addr` out XLEN: miss address.

## Operation
- Address split:
  - index = `pc[ICACHE_SIZE_WIDTH:1]`
  - tag = `pc[XLEN-1:ICACHE_SIZE_WIDTH+1]`
  - `pc[0]` is ignored.
- Storage per line: valid bit, tag, XLEN data. All valid bits are cleared on `rst` and are never cleared by `flush`.
- FSM states:
  - IDLE: accepts `ifetch_enable`.
    - Hit (valid and tag equal): register `icache_ready`=1, `icache_inst`=line data, `icache_pc`=`ifetch_pc` for the next cycle. Remain in IDLE.
    - Miss: latch `ifetch_pc` into `miss_addr`. Go to REQ.
  - REQ: combinational `icache_mem_enable` = !`mem_busy` && !`stall` && !`flush` && `rdy`, with `icache_inst_addr`=`miss_addr`. When asserted, go to WAIT and clear the `armed` flag.
  - WAIT: the first cycle only sets `armed`=1; any `mem_inst_ready` seen that cycle is stale and is ignored. Afterwards, `mem_inst_ready` && `mem_inst_addr`==`miss_addr` triggers:
    - write the line (valid=1, tag, `mem_inst`);
    - drive `icache_ready`=1, `icache_inst`=`mem_inst`, `icache_pc`=`miss_addr` on the next cycle;
    - go to IDLE.
  - A return with a mismatched address is ignored.
- `ifetch_enable` outside IDLE is ignored. Fetch holds `ifetch_enable` and `ifetch_pc` until it sees `icache_ready`, and may present the next pc during the `icache_ready` cycle.
- `flush` (rdy=1) has priority over everything except `rst`:
  - state goes to IDLE;
  - `icache_ready` goes to 0;
  - any outstanding miss is abandoned (the memory controller drops it on the same flush);
  - the array is untouched, including a fill arriving in the same cycle (dropped).
- `stall`=1 or `rdy`=0: no register changes, and `icache_mem_enable`=0.
- `icache_ready` is 0 in every cycle not described above.

## Timing
- Reset values:
  - `icache_ready`=0, `icache_inst`=0, `icache_pc`=0.
  - `icache_mem_enable`=0 and `icache_inst_addr`=0, because state is IDLE and `miss_addr`=0.
  - All valid bits 0.
- Hit latency: request in cycle N, `icache_ready` in N+1. Throughput is one hit per cycle.
- Miss: request in N, REQ in N+1, `icache_mem_enable` in N+1 if the controller is idle. The controller returns at M ≥ N+4, and `icache_ready` rises at M+1.
- `icache_mem_enable` is a single-cycle pulse per miss. It is never re-asserted until the FSM returns to IDLE and takes a new miss.
- A fill and a lookup never share a cycle, because fills occur only in WAIT. No read/write bypass is needed.
- `rst` asserted mid-miss: state goes to IDLE immediately (asynchronous) and outputs take their reset values.

## Test plan
- Reset, then fetch `0x0000_0000`: miss. `icache_mem_enable`=1 with `icache_inst_addr`=0 one cycle later. Return `mem_inst`=`0x0000_0513` with `mem_inst_addr`=0. `icache_ready`=1 one cycle later with `icache_inst`=`0x0000_0513`. Re-fetching 0 then hits in 1 cycle.
- Hit streaming: preload `0x0`, `0x4`, `0x8`, then fetch them back-to-back. Require `icache_ready` on three consecutive cycles with the matching `icache_pc`, and `icache_mem_enable` never asserted.
- Conflict: fill `0x0000_0004`, then fetch `0x0000_0084` (same index, 64 lines). Require a miss and a refill. A subsequent fetch of `0x4` must miss again.
- Compressed instruction at `0x2`: return `mem_inst`=`0x0000_4501`. The line at index 1 holds `0x0000_4501`, and `0x2` hits afterwards.
- Flush in WAIT: miss on `0x100`, assert `flush` for one cycle, then return `0x100` data. Require no `icache_ready` and no array write, and a later fetch of `0x100` misses.
- `mem_busy`=1 for 5 cycles while in REQ: `icache_mem_enable` stays 0 throughout. It fires in the first cycle after `mem_busy` falls. `stall`=1 in that cycle delays it by one cycle.
